test_status_mmio: RTL and testbench

//  Memory-mapped test-completion responder on the RV32IMA data bus. Firmware

---
 rtl/rv32ima_pkg.sv | 36 +++
 rtl/tstat_cycle_counter.sv | 38 +++
 rtl/test_status_mmio.sv | 144 ++++++++++++++
 tb/tb_test_status_mmio.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32ima_pkg.sv
// Shared types for the RV32IMA SoC slice: word type, test-status FSM
// encodings, register offsets and a byte-enable merge helper.
package rv32ima_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2,
    TMO  = 2'd3
  } tstat_state_t;

  typedef enum logic {
    B_IDLE = 1'b0,
    B_RESP = 1'b1
  } bus_state_t;

  localparam logic [4:0] TSTAT_OFF_STATUS   = 5'h00;
  localparam logic [4:0] TSTAT_OFF_TOHOST   = 5'h04;
  localparam logic [4:0] TSTAT_OFF_CYCLE_LO = 5'h08;
  localparam logic [4:0] TSTAT_OFF_CYCLE_HI = 5'h0C;
  localparam logic [4:0] TSTAT_OFF_TIMEOUT  = 5'h10;
  localparam logic [4:0] TSTAT_OFF_SCRATCH  = 5'h14;

  // Replace only the byte lanes selected by be.
  function automatic word_t tstat_merge_be(word_t old_w, word_t new_w, logic [3:0] be);
    word_t r;
    r = old_w;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/tstat_cycle_counter.sv
// 64-bit free-running cycle counter for the test-status block.
// Counts while en_i is high (freezes otherwise) and captures the high word
// into a shadow when the low word is read, so LO-then-HI reads are coherent.
module tstat_cycle_counter (
  input  logic        clk,
  input  logic        nrst,
  input  logic        en_i,
  input  logic        snap_i,
  output logic [63:0] cnt_o,
  output logic [31:0] shadow_hi_o
);

  logic [63:0] cnt_q, cnt_d;
  logic [31:0] shadow_q, shadow_d;

  // Next count (wraps naturally at 2^64) and shadow capture.
  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    if (en_i)   cnt_d    = cnt_q + 64'd1;
    if (snap_i) shadow_d = cnt_q[63:32];
  end

  // Counter and shadow registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign shadow_hi_o = shadow_q;

endmodule

// File: rtl/test_status_mmio.sv
// Memory-mapped test-completion responder. Firmware writes a pass magic or
// fail code to TOHOST; the block latches a sticky verdict, halts the core
// and freezes the cycle counter.
// Optional watchdog: define TEST_STATUS_WATCHDOG_EN to enable TIMEOUT -> TMO.
module test_status_mmio
  import rv32ima_pkg::*;
#(
  parameter word_t PASS_MAGIC      = 32'hBEEF_BEEF,
  parameter word_t DEFAULT_TIMEOUT = 32'd0
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       sel,
  input  logic       dren,
  input  logic       dwen,
  input  logic [4:0] addr,
  input  word_t      wdata,
  input  logic [3:0] byte_en,
  output word_t      rdata,
  output logic       ready,
  output logic       halt,
  output logic       done,
  output logic       pass,
  output word_t      status_word
);

  bus_state_t   bus_q, bus_d;
  tstat_state_t vstate_q, vstate_d;
  word_t        rdata_q, rdata_d;
  word_t        timeout_q, timeout_d;
  word_t        scratch_q, scratch_d;
  word_t        status_q, status_d;

  logic [4:0]   off;
  logic         tohost_wr;
  logic         snap_lo;
  logic         tmo_hit;
  logic [63:0]  cnt;
  logic [31:0]  shadow_hi;

  assign off = {addr[4:2], 2'b00};

  tstat_cycle_counter u_cycle (
    .clk         (clk),
    .nrst        (nrst),
    .en_i        (vstate_q == RUN),
    .snap_i      (snap_lo),
    .cnt_o       (cnt),
    .shadow_hi_o (shadow_hi)
  );

`ifdef TEST_STATUS_WATCHDOG_EN
  assign tmo_hit = (timeout_q != '0) && (cnt >= {32'b0, timeout_q});
`else
  assign tmo_hit = 1'b0;
  logic unused_cnt_hi;
  assign unused_cnt_hi = ^cnt[63:32];
`endif

  // Bus handshake, register decode and read mux; the access is performed on
  // the capture edge so its effects are visible while ready is high.
  always_comb begin
    bus_d     = bus_q;
    rdata_d   = '0;
    timeout_d = timeout_q;
    scratch_d = scratch_q;
    tohost_wr = 1'b0;
    snap_lo   = 1'b0;
    case (bus_q)
      B_IDLE: begin
        if (sel && (dren || dwen)) begin
          bus_d = B_RESP;
          if (dwen) begin
            case (off)
              TSTAT_OFF_TOHOST:  tohost_wr = (byte_en == 4'hF);
              TSTAT_OFF_TIMEOUT: timeout_d = tstat_merge_be(timeout_q, wdata, byte_en);
              TSTAT_OFF_SCRATCH: scratch_d = tstat_merge_be(scratch_q, wdata, byte_en);
              default: ;
            endcase
          end else begin
            case (off)
              TSTAT_OFF_STATUS:   rdata_d = {29'd0, vstate_q != RUN, vstate_q};
              TSTAT_OFF_CYCLE_LO: begin
                rdata_d = cnt[31:0];
                snap_lo = 1'b1;
              end
              TSTAT_OFF_CYCLE_HI: rdata_d = shadow_hi;
              TSTAT_OFF_TIMEOUT:  rdata_d = timeout_q;
              TSTAT_OFF_SCRATCH:  rdata_d = scratch_q;
              default: ;
            endcase
          end
        end
      end
      B_RESP:  bus_d = B_IDLE;
      default: bus_d = B_IDLE;
    endcase
  end

  // Verdict FSM: a valid TOHOST write takes priority over a watchdog hit.
  always_comb begin
    vstate_d = vstate_q;
    status_d = status_q;
    if (vstate_q == RUN) begin
      if (tohost_wr && (wdata == PASS_MAGIC)) begin
        vstate_d = PASS;
        status_d = '0;
      end else if (tohost_wr && (wdata != '0)) begin
        vstate_d = FAIL;
        status_d = wdata;
      end else if (tmo_hit) begin
        vstate_d = TMO;
        status_d = '1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bus_q     <= B_IDLE;
      vstate_q  <= RUN;
      rdata_q   <= '0;
      timeout_q <= DEFAULT_TIMEOUT;
      scratch_q <= '0;
      status_q  <= '0;
    end else begin
      bus_q     <= bus_d;
      vstate_q  <= vstate_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
      scratch_q <= scratch_d;
      status_q  <= status_d;
    end
  end

  assign rdata       = rdata_q;
  assign ready       = (bus_q == B_RESP);
  assign done        = (vstate_q != RUN);
  assign halt        = (vstate_q != RUN);
  assign pass        = (vstate_q == PASS);
  assign status_word = status_q;

endmodule

// File: tb/tb_test_status_mmio.sv
// Randomized self-checking bench for test_status_mmio against a
// transaction-level reference model.
module tb_test_status_mmio;

  localparam logic [31:0] MAGIC = 32'hBEEF_BEEF;
`ifdef TEST_STATUS_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic        sel, dren, dwen;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  byte_en;
  logic [31:0] rdata;
  logic        ready, halt, done, pass;
  logic [31:0] status_word;

  int n_vec = 0;
  int n_err = 0;

  test_status_mmio #(.PASS_MAGIC(MAGIC), .DEFAULT_TIMEOUT(32'd0)) dut (
    .clk(clk), .nrst(nrst), .sel(sel), .dren(dren), .dwen(dwen),
    .addr(addr), .wdata(wdata), .byte_en(byte_en), .rdata(rdata),
    .ready(ready), .halt(halt), .done(done), .pass(pass),
    .status_word(status_word)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // m_state: 0 run, 1 pass, 2 fail, 3 timeout
  logic [1:0]  m_state;
  logic [63:0] m_cycle;
  logic [31:0] m_status, m_timeout, m_scratch, m_shadow, m_rdata;
  bit          m_busy;
  logic [63:0] load_val;
  int          load_req = 0;
  int          load_ack = 0;

  function automatic logic [31:0] be_merge(logic [31:0] o, logic [31:0] n, logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
    return (o & ~m) | (n & m);
  endfunction

  always @(posedge clk or negedge nrst) begin
    logic [1:0]  old_state;
    logic [31:0] old_to;
    logic [63:0] c;
    logic [4:0]  o;
    bit          verdict;
    if (!nrst) begin
      m_state = 0; m_cycle = 0; m_status = 0; m_timeout = 0;
      m_scratch = 0; m_shadow = 0; m_rdata = 0; m_busy = 0;
    end else begin
      if (load_req != load_ack) begin
        m_cycle  = load_val;
        load_ack = load_req;
      end
      old_state = m_state;
      old_to    = m_timeout;
      c         = m_cycle;
      verdict   = 0;
      if (m_busy) begin
        m_busy  = 0;
        m_rdata = 0;
      end else if (sel && (dren || dwen)) begin
        m_busy  = 1;
        m_rdata = 0;
        o = addr & 5'h1C;
        if (dwen) begin
          if (o == 5'h04 && byte_en == 4'hF && old_state == 0 && wdata != 0) begin
            verdict = 1;
            if (wdata == MAGIC) begin m_state = 1; m_status = 0; end
            else begin m_state = 2; m_status = wdata; end
          end
          if (o == 5'h10) m_timeout = be_merge(m_timeout, wdata, byte_en);
          if (o == 5'h14) m_scratch = be_merge(m_scratch, wdata, byte_en);
        end else begin
          case (o)
            5'h00: m_rdata = {29'd0, old_state != 0, old_state};
            5'h08: begin m_rdata = c[31:0]; m_shadow = c[63:32]; end
            5'h0C: m_rdata = m_shadow;
            5'h10: m_rdata = m_timeout;
            5'h14: m_rdata = m_scratch;
            default: m_rdata = 0;
          endcase
        end
      end
      if (WD && old_state == 0 && !verdict && old_to != 0 && c >= {32'd0, old_to}) begin
        m_state  = 3;
        m_status = 32'hFFFF_FFFF;
      end
      if (old_state == 0) m_cycle = c + 64'd1;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus access; caller is positioned at a negedge.
  task automatic bus_access(input string tag, input bit r, input bit w, input logic [4:0] a,
                            input logic [31:0] d, input logic [3:0] be, output logic [31:0] rv);
    sel = 1'b1; dren = r; dwen = w; addr = a; wdata = d; byte_en = be;
    @(negedge clk);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_rdata"}, rdata, m_rdata);
    chk({tag, "_done"}, done, m_state != 0);
    chk({tag, "_halt"}, halt, m_state != 0);
    chk({tag, "_pass"}, pass, m_state == 1);
    chk({tag, "_status"}, status_word, m_status);
    rv = rdata;
    sel = 1'b0; dren = 1'b0; dwen = 1'b0;
    @(negedge clk);
    chk({tag, "_ready_low"}, ready, 0);
  endtask

  task automatic rd(input string tag, input logic [4:0] a, output logic [31:0] rv);
    bus_access(tag, 1'b1, 1'b0, a, $urandom, 4'h0, rv);
  endtask

  task automatic wr(input string tag, input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] dummy;
    bus_access(tag, 1'b0, 1'b1, a, d, be, dummy);
  endtask

  task automatic do_reset();
    sel = 0; dren = 0; dwen = 0; addr = 0; wdata = 0; byte_en = 0;
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_halt", halt, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_status", status_word, 0);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_cycle(input logic [63:0] v);
    @(negedge clk);
    force dut.u_cycle.cnt_q = v;
    load_val = v;
    load_req++;
    #1 release dut.u_cycle.cnt_q;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] v, code;
    logic [4:0]  a;
    logic [3:0]  be;
    nrst = 1'b1;
    sel = 0; dren = 0; dwen = 0; addr = 0; wdata = 0; byte_en = 0;
    #3;
    do_reset();

    rd("status0", 5'h00, v);
    chk("status0_val", v, 0);

    // request without sel is not acknowledged
    dren = 1'b1; addr = 5'h00;
    @(negedge clk);
    chk("nosel_ready", ready, 0);
    dren = 1'b0;

    // randomized register traffic (no verdict writes)
    for (int i = 0; i < 40; i++) begin
      be = 4'($urandom);
      case ($urandom_range(0, 6))
        0: wr("r_scr_wr", 5'h14 | 5'($urandom_range(0, 3)), $urandom, be);
        1: rd("r_scr_rd", 5'h14, v);
        2: begin rd("r_lo", 5'h08, v); rd("r_hi", 5'h0C, v); end
        3: begin
             a = ($urandom_range(0, 1) != 0) ? 5'h18 : 5'h1C;
             a = a | 5'($urandom_range(0, 3));
             if ($urandom_range(0, 1) != 0) wr("r_unm_wr", a, $urandom, be);
             else rd("r_unm_rd", a, v);
           end
        4: begin
             if ($urandom_range(0, 1) != 0) wr("r_toh_zero", 5'h04, 32'h0, 4'hF);
             else wr("r_toh_part", 5'h04, $urandom | 32'h1, (be == 4'hF) ? 4'h7 : be);
           end
        5: bus_access("r_rdwr", 1'b1, 1'b1, 5'h14, $urandom, be, v);
        default: begin rd("r_status", 5'h00, v); rd("r_toh_rd", 5'h04, v); end
      endcase
    end

    // byte-enable behaviour and TIMEOUT storage
    wr("scr_clr", 5'h14, 32'h0, 4'hF);
    wr("scr_be2", 5'h14, 32'hAABB_CCDD, 4'h2);
    rd("scr_chk", 5'h14, v);
    chk("scr_be2_val", v, 32'h0000_CC00);
    wr("tmo_store", 5'h10, 32'h1234_5678, 4'hF);
    rd("tmo_rd", 5'h10, v);
    chk("tmo_store_val", v, 32'h1234_5678);
    wr("tmo_clr", 5'h10, 32'h0, 4'hF);
    wr("toh_part_beef", 5'h04, 32'h0000_BEEF, 4'h3);
    rd("status_run", 5'h00, v);
    chk("status_run_val", v, 0);

    // coherent 64-bit read across the low-word carry
    load_cycle(64'h0000_0000_FFFF_FFFD);
    rd("carry_lo", 5'h08, v);
    rd("carry_hi", 5'h0C, v);
    rd("carry_lo2", 5'h08, v);
    rd("carry_hi2", 5'h0C, v);
    chk("carry_hi2_val", v, 1);
    // 64-bit wrap
    load_cycle(64'hFFFF_FFFF_FFFF_FFFC);
    rd("wrap_lo", 5'h08, v);
    rd("wrap_hi", 5'h0C, v);
    chk("wrap_hi_val", v, 32'hFFFF_FFFF);
    rd("wrap_lo2", 5'h08, v);
    rd("wrap_hi2", 5'h0C, v);
    chk("wrap_hi2_val", v, 0);

    // PASS verdict is sticky
    do_reset();
    wr("pass_wr", 5'h04, MAGIC, 4'hF);
    rd("pass_status", 5'h00, v);
    chk("pass_status_val", v, 32'h5);
    chk("pass_flag", pass, 1);
    wr("pass_then_fail", 5'h04, 32'h0000_0007, 4'hF);
    rd("pass_status2", 5'h00, v);
    chk("pass_sticky", v, 32'h5);
    rd("frz_lo", 5'h08, v);
    repeat (5) @(negedge clk);
    rd("frz_lo2", 5'h08, v);

    // FAIL verdict with a random code
    do_reset();
    code = $urandom | 32'h1;
    if (code == MAGIC) code = 32'h7;
    wr("fail_wr", 5'h04, code, 4'hF);
    chk("fail_code", status_word, code);
    rd("fail_status", 5'h00, v);
    chk("fail_status_val", v, 32'h6);
    wr("fail_then_pass", 5'h04, MAGIC, 4'hF);
    chk("fail_sticky_pass", pass, 0);
    chk("fail_sticky_code", status_word, code);

    // reset during an access drops ready immediately
    do_reset();
    sel = 1'b1; dren = 1'b1; addr = 5'h00;
    @(negedge clk);
    chk("mid_ready", ready, 1);
    nrst = 1'b0;
    #1;
    chk("mid_ready_drop", ready, 0);
    sel = 1'b0; dren = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    rd("mid_reissue", 5'h00, v);

    // TIMEOUT set, no TOHOST write
    do_reset();
    wr("wd_set", 5'h10, 32'd30, 4'hF);
    for (int i = 0; i < 200 && m_state == 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("wd_done", done, m_state != 0);
    chk("wd_status_word", status_word, m_status);
    rd("wd_status", 5'h00, v);
    rd("wd_lo", 5'h08, v);
    repeat (3) @(negedge clk);
    rd("wd_lo2", 5'h08, v);

    // TOHOST write landing on the watchdog hit cycle
    do_reset();
    wr("race_set", 5'h10, 32'd40, 4'hF);
    for (int i = 0; i < 200 && m_cycle != 64'd40; i++) @(negedge clk);
    chk("race_align", m_cycle, 64'd40);
    wr("race_wr", 5'h04, MAGIC, 4'hF);
    chk("race_pass", pass, 1);
    chk("race_status_word", status_word, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
